// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, FSM states and fault decode for the instruction memory
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {ST_CLEAR, ST_READY} imem_state_e;

  // Misaligned, or any address bit above the word-index field set within addr_w.
  function automatic logic addr_fault(input logic [63:0] addr, input int addr_w, input int idx_w);
    logic [63:0] hi_mask;
    hi_mask = ((64'd1 << addr_w) - 64'd1) & ~((64'd1 << (idx_w + 2)) - 64'd1);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 64'd0);
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// rtl/imem_ram_1r1w.sv - one-write one-read instruction array with registered, write-first read
module imem_ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/imem_bank.sv
// rtl/imem_bank.sv - instruction memory: boot clear to NOP, load port, registered fetch with faults
module imem_bank
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data
);

  imem_state_e       state;
  logic [IDX_W-1:0]  clr_cnt;
  logic              fetch_acc;
  logic              fault;
  logic [IDX_W-1:0]  fetch_idx;
  logic              ram_we;
  logic              ram_re;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              instr_sel;

  assign fetch_acc = (state == ST_READY) && fetch_req;
  assign fault     = addr_fault(64'(fetch_addr), ADDR_W, IDX_W);
  assign fetch_idx = fetch_addr[IDX_W+1:2];

  // Clear owns the write port until boot finishes; loads are dropped meanwhile.
  assign ram_we    = (state == ST_CLEAR) || load_en;
  assign ram_waddr = (state == ST_CLEAR) ? clr_cnt : load_idx;
  assign ram_wdata = (state == ST_CLEAR) ? DATA_W'(NOP_INSTR) : load_data;
  assign ram_re    = fetch_acc && !fault;

  imem_ram_1r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_idx),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_CLEAR;
      clr_cnt     <= '0;
      ready       <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      instr_sel   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state <= ST_READY;
            ready <= 1'b1;
          end
        end
        default: ;
      endcase
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_fault <= fault;
        instr_sel   <= !fault;
      end
    end
  end

  // The array has no reset, so the response word is gated to NOP until a good fetch lands.
  assign fetch_instr = instr_sel ? ram_rdata : DATA_W'(NOP_INSTR);

endmodule

// File: doc/imem_bank.md
# imem_bank

Parametrised instruction memory for the single-cycle/pipelined MIPS core. It replaces the hard-coded, clock-rewritten program store with a RAM that is cleared to NOP after reset, loaded through a write port by the testbench or boot loader, and read through a registered fetch port. Fetch responses carry a valid flag and report misaligned or out-of-range addresses as faults. The block sits between the PC/fetch stage and the program loader.

## Interface
- DATA_W, 32, instruction width in bits
- DEPTH, 64, number of instruction words; power of two, ≥ 4
- ADDR_W, 32, byte-address width of the fetch port
- IDX_W, $clog2(DEPTH), word-index width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ready  out  1  high once boot clear has finished
- fetch_req  in  1  fetch request, sampled on the rising edge of clk
- fetch_addr  in  ADDR_W  byte address of the instruction
- fetch_valid  out  1  response valid, one cycle after an accepted request
- fetch_instr  out  DATA_W  instruction word; 0 (NOP) on a fault
- fetch_fault  out  1  response fault: misaligned or out of range
- load_en  in  1  write strobe
- load_idx  in  IDX_W  word index to write
- load_data  in  DATA_W  word to write

## Operation
- Two-state FSM: CLEAR and READY.
- Reset asserted: FSM→CLEAR, clear counter→0, ready=0, fetch_valid=0, fetch_fault=0, fetch_instr=0. Array contents are not reset asynchronously.
- CLEAR: writes 0 to word[counter] each cycle, then increments the counter. After writing DEPTH−1 the FSM moves to READY. fetch_req and load_en are ignored, with no response and no write.
- READY: stays in READY until reset.
- Fetch is accepted when FSM=READY and fetch_req=1.
- word index = fetch_addr[IDX_W+1:2].
- fault = (fetch_addr[1:0]≠0) OR (fetch_addr[ADDR_W-1:IDX_W+2]≠0).
- On a fault, fetch_instr=0 and fetch_fault=1. Otherwise fetch_instr=word[index] and fetch_fault=0.
- Load writes only in READY: when load_en=1, word[load_idx] is written at the clock edge.
- Fetch and load to the same index in the same cycle: write-first, so the response carries load_data.
- Fetch and load to different indices in the same cycle are independent.
- No request in a cycle: fetch_valid drops to 0 in the next cycle. fetch_instr and fetch_fault hold their last values.

## Timing
- Fetch latency is exactly 1 cycle. A request at edge N gives fetch_valid, fetch_instr and fetch_fault valid after edge N, held until edge N+1.
- Throughput is one fetch per cycle, with no back-pressure.
- Boot clear takes DEPTH cycles. ready rises after the DEPTH-th edge following reset release, and the first fetch can be accepted on that edge's successor.
- A load becomes visible to a fetch in the same cycle (write-first) and to all later fetches.
- Reset asserted mid-CLEAR or mid-READY: outputs go to reset values immediately (asynchronously). Clear restarts from index 0 after release. Any in-flight response is dropped.
- ready is registered and only changes on a clock edge or on reset.

## Structure
- Package imem_pkg:
  - NOP_INSTR = 32'h0000_0000
  - FSM state enum {ST_CLEAR, ST_READY}
  - function returning the fault predicate for a given ADDR_W/IDX_W
- Sub-module imem_ram_1r1w (DATA_W, DEPTH): synchronous write; registered read with a write-first bypass. It holds only the array, with no reset.
- Top level holds the FSM, the clear counter, the mux that selects clear writes or load writes, fault decode, and the response registers.

## Test plan
- Boot: reset for 3 cycles, release. ready=0 for 64 cycles then 1. fetch_req=1 throughout CLEAR gives fetch_valid=0. A fetch of addr 0x0 after ready gives instr 0x00000000, fault=0.
- Load/fetch: load idx 0 = 0x20080020 and idx 1 = 0x20090037, then fetch 0x0 and 0x4 back-to-back. The responses are the two words on consecutive cycles, valid=1 both cycles.
- Same-cycle collision: load idx 5 = 0xAC100004 while fetching 0x14. The next-cycle response is 0xAC100004.
- Faults:
  - fetch 0x6 gives fault=1, instr=0
  - fetch 0x100 (index 64, DEPTH=64) gives fault=1, instr=0
  - fetch 0xFC gives fault=0 with word 63
- Reset mid-operation:
  - assert rst_n=0 during a fetch: fetch_valid drops immediately and ready=0
  - after release, clear restarts; earlier loaded words read back 0 once ready
- Idle gap: request, idle, request gives fetch_valid pattern 1,0,1.
